// File: rtl/mux_arb_pkg.sv
// Shared types for the round-robin channel mux: FSM state encoding and select-width helper.
// No logic, so no latency.
// No handshake, so no backpressure.
package mux_arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Select width never collapses to zero, so a single-channel build still has a 1-bit out_sel.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last accepted channel.
// Grant is combinational from req; last_grant advances one cycle after an accepted beat.
// The arbiter has no stall of its own: the caller withholds advance until the beat is accepted.
module rr_arbiter #(
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NUM_IN-1:0] req,
   input  logic              advance,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx
);

   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] cand;
   logic             found;

   // Scan last_grant+1 .. last_grant+NUM_IN so the previous winner has lowest priority.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = SEL_W'((int'(last_grant) + k) % NUM_IN);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_grant <= SEL_W'(NUM_IN - 1);
      end else if (advance) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/mux_arb_rr.sv
// NUM_IN-channel valid/ready mux, round-robin arbitrated, one registered output beat (MUX_ARB_FORCE_SEL_EN adds a fixed-select override).
// Latency 1 cycle in->out; 1 beat/cycle with out_ready held high, drain and refill in the same cycle.
// Backpressure: while the held beat is stalled (out_valid && !out_ready) every in_ready is 0.
module mux_arb_rr
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
`ifdef MUX_ARB_FORCE_SEL_EN
   input  logic                    force_en,
   input  logic [SEL_W-1:0]        force_sel,
`endif
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_sel
);

   state_t            state;
   logic [NUM_IN-1:0] arb_grant;
   logic [SEL_W-1:0]  arb_idx;
   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  sel_idx;
   logic [WIDTH-1:0]  sel_data;
   logic              load;
   logic              accept;
   logic              advance;

   rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_arb (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req       (in_valid),
      .advance   (advance),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

`ifdef MUX_ARB_FORCE_SEL_EN
   // Forced select never falls back to round-robin; an out-of-range index matches no channel.
   always_comb begin
      grant   = '0;
      sel_idx = arb_idx;
      if (force_en) begin
         sel_idx = force_sel;
         for (int i = 0; i < NUM_IN; i++) begin
            if (force_sel == SEL_W'(i) && in_valid[i]) grant[i] = 1'b1;
         end
      end else begin
         grant = arb_grant;
      end
   end
   assign advance = accept && !force_en;
`else
   assign grant   = arb_grant;
   assign sel_idx = arb_idx;
   assign advance = accept;
`endif

   assign load     = !out_valid || out_ready;
   assign accept   = RST_N && load && (|grant);
   assign in_ready = (RST_N && load) ? grant : '0;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state     <= ST_FULL;
                  out_valid <= 1'b1;
                  out_data  <= sel_data;
                  out_sel   <= sel_idx;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  if (accept) begin
                     out_data <= sel_data;
                     out_sel  <= sel_idx;
                  end else begin
                     state     <= ST_EMPTY;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
